mem_arb: RTL and testbench
==========================

// Module: mem_arb
// PURPOSE
//  Arbiter sharing one unified single-port memory between the fetch stage (imem requester) and
//  the memory stage (dmem requester). One transaction outstanding at a time; data side has
//  priority (older instruction), with a starvation guard so fetch always progresses. Sits
//  between fe/mem stages and the memory model; fetch flush cancels an in-flight imem read.
// PARAMETERS
//  ADDR_W      32  address width
//  DATA_W      32  data width (mask width DATA_W/8)
//  STARVE_MAX  4   consecutive dmem wins over a waiting imem before imem is forced (>=1)
// PORTS
//  i_clk          in   1        clock; all logic on posedge
//  i_rst_n        in   1        synchronous reset, active-low
//  i_flush        in   1        fetch flush; discard pending/in-flight imem response
//  i_imem_req     in   1        fetch read request, held until o_imem_gnt
//  i_imem_addr    in   ADDR_W   fetch address
//  o_imem_gnt     out  1        imem request accepted this cycle
//  o_imem_vld     out  1        o_imem_rdata valid (1 cycle pulse)
//  o_imem_rdata   out  DATA_W   fetched instruction
//  i_dmem_req     in   1        load/store request, held until o_dmem_gnt
//  i_dmem_wen     in   1        1 = store, 0 = load
//  i_dmem_addr    in   ADDR_W   data address
//  i_dmem_wdata   in   DATA_W   store data
//  i_dmem_mask    in   DATA_W/8 byte enables
//  o_dmem_gnt     out  1        dmem request accepted this cycle
//  o_dmem_vld     out  1        load data valid / store ack (1 cycle pulse)
//  o_dmem_rdata   out  DATA_W   load data (0 on store ack)
//  o_mem_req/o_mem_wen/o_mem_addr/o_mem_wdata/o_mem_mask  out  1/1/ADDR_W/DATA_W/DATA_W/8  to memory
//  i_mem_vld      in   1        memory response/ack, >=1 cycle after o_mem_req
//  i_mem_rdata    in   DATA_W   memory read data
// BEHAVIOUR
//  - States: IDLE, BUSY_I, BUSY_D. Reset (i_rst_n=0 at posedge): state IDLE, starve cnt 0,
//    drop flag 0, all outputs 0; any outstanding transaction abandoned.
//  - IDLE: grant combinational same cycle; o_mem_* = granted requester's fields, o_mem_req=gnt.
//    Only dmem req -> dmem; only imem req -> imem (unless i_flush=1: no grant).
//    Both -> dmem, unless starve cnt==STARVE_MAX -> imem. Next state BUSY_D / BUSY_I.
//  - BUSY_x: no grants, o_mem_req=0; on i_mem_vld route i_mem_rdata to owner, pulse its vld,
//    return to IDLE. New grant earliest the cycle after i_mem_vld (min 2 cycles/transaction).
//  - i_mem_vld while IDLE: ignored (stale after reset).
//  - Starve cnt: +1 on each dmem grant while i_imem_req=1 (saturate at STARVE_MAX);
//    clears on any imem grant or when i_imem_req=0 in IDLE.
//  - Flush: i_flush in BUSY_I sets drop; response consumed, o_imem_vld suppressed, drop cleared.
//    i_flush in IDLE blocks an imem grant that cycle. No effect on dmem path.
//  - o_*_rdata registered off i_mem_rdata; latency vld-in -> vld-out = 1 cycle.
// CONFIGURATION
//  MEM_ARB_STATS_EN defined: adds o_conflict_cnt[31:0] (cycles both req in IDLE) and
//  o_istall_cnt[31:0] (cycles i_imem_req=1 without gnt); saturating, reset 0.
//  Undefined: ports and counters absent; arbitration identical.
// STRUCTURE
//  mem_arb_pkg: state encoding (IDLE/BUSY_I/BUSY_D), owner codes, default STARVE_MAX.
//  Sub-module mem_arb_prio: combinational pick (req_i, req_d, flush, starve_hit) -> gnt_i/gnt_d.
// TESTING
//  1 imem req addr 0x100, mem vld 2 cycles later rdata 0x00000033 -> gnt same cycle, imem_vld next.
//  2 imem+dmem load same cycle, cnt 0 -> dmem gnt; imem gnt after dmem vld+1.
//  3 dmem req held continuously, imem waiting, STARVE_MAX=4 -> 4 dmem grants then imem granted.
//  4 imem granted, i_flush in BUSY_I, mem vld -> o_imem_vld stays 0, state IDLE next cycle.
//  5 store wdata 0xDEADBEEF mask 4'b0011 -> o_mem_* match, o_dmem_vld on ack, rdata 0.
//  6 reset mid BUSY_D then stale i_mem_vld -> no vld pulses, outputs 0; STATS counts match.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state/owner encodings and default starvation limit for mem_arb.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2} state_e;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_I = 2'd1, OWN_D = 2'd2} owner_e;
  localparam int STARVE_MAX_DEF = 4;
  function automatic owner_e owner_of(state_e s);
    return s == BUSY_I ? OWN_I : s == BUSY_D ? OWN_D : OWN_NONE;
  endfunction
endpackage

// File: rtl/mem_arb_prio.sv
// mem_arb_prio: combinational imem/dmem pick; dmem wins unless fetch is starving.
module mem_arb_prio (
  input  logic req_i,
  input  logic req_d,
  input  logic flush,
  input  logic starve_hit,
  output logic gnt_i,
  output logic gnt_d
);
  // a flushed fetch never wins, so dmem may still go in that cycle
  assign gnt_i = req_i & ~flush & (~req_d | starve_hit);
  assign gnt_d = req_d & ~gnt_i;
endmodule

// File: rtl/mem_arb.sv
// mem_arb: single-outstanding arbiter of one memory port between fetch and data requesters.
// Optional MEM_ARB_STATS_EN adds saturating conflict / fetch-stall counters.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_flush,
  input  logic                i_imem_req,
  input  logic [ADDR_W-1:0]   i_imem_addr,
  output logic                o_imem_gnt,
  output logic                o_imem_vld,
  output logic [DATA_W-1:0]   o_imem_rdata,
  input  logic                i_dmem_req,
  input  logic                i_dmem_wen,
  input  logic [ADDR_W-1:0]   i_dmem_addr,
  input  logic [DATA_W-1:0]   i_dmem_wdata,
  input  logic [DATA_W/8-1:0] i_dmem_mask,
  output logic                o_dmem_gnt,
  output logic                o_dmem_vld,
  output logic [DATA_W-1:0]   o_dmem_rdata,
  output logic                o_mem_req,
  output logic                o_mem_wen,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_mask,
  input  logic                i_mem_vld,
  input  logic [DATA_W-1:0]   i_mem_rdata
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]         o_conflict_cnt,
  output logic [31:0]         o_istall_cnt
`endif
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  state_e            state_q, state_d;
  logic [CW-1:0]     starve_q, starve_d;
  logic              drop_q, drop_d;
  logic              st_q, st_d;
  logic              ivld_q, dvld_q;
  logic [DATA_W-1:0] irdata_q, drdata_q;
  logic              idle, starve_hit, gnt_i, gnt_d, rsp_i, rsp_d;
  owner_e            owner;
  // grants are held off while reset is asserted so outputs stay quiet
  assign idle       = i_rst_n & (state_q == IDLE);
  assign starve_hit = starve_q == CW'(STARVE_MAX);
  assign owner      = owner_of(state_q);
  mem_arb_prio u_prio (
    .req_i     (idle & i_imem_req),
    .req_d     (idle & i_dmem_req),
    .flush     (i_flush),
    .starve_hit(starve_hit),
    .gnt_i     (gnt_i),
    .gnt_d     (gnt_d)
  );
  assign o_imem_gnt  = gnt_i;
  assign o_dmem_gnt  = gnt_d;
  assign o_mem_req   = gnt_i | gnt_d;
  assign o_mem_wen   = gnt_d & i_dmem_wen;
  assign o_mem_addr  = gnt_d ? i_dmem_addr : gnt_i ? i_imem_addr : '0;
  assign o_mem_wdata = gnt_d ? i_dmem_wdata : '0;
  assign o_mem_mask  = gnt_d ? i_dmem_mask : '0;
  assign rsp_i = i_mem_vld & (owner == OWN_I) & ~drop_q & ~i_flush;
  assign rsp_d = i_mem_vld & (owner == OWN_D);
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    drop_d   = drop_q;
    st_d     = st_q;
    if (state_q == IDLE) begin
      state_d  = gnt_i ? BUSY_I : gnt_d ? BUSY_D : IDLE;
      starve_d = (gnt_i | ~i_imem_req) ? '0 : (gnt_d & ~starve_hit) ? starve_q + 1'b1 : starve_q;
      st_d     = gnt_d ? i_dmem_wen : st_q;
    end else if (state_q == BUSY_I || state_q == BUSY_D) begin
      drop_d  = (drop_q | (state_q == BUSY_I & i_flush)) & ~i_mem_vld;
      state_d = i_mem_vld ? IDLE : state_q;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      starve_q <= '0;
      drop_q   <= 1'b0;
      st_q     <= 1'b0;
      ivld_q   <= 1'b0;
      dvld_q   <= 1'b0;
      irdata_q <= '0;
      drdata_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      drop_q   <= drop_d;
      st_q     <= st_d;
      ivld_q   <= rsp_i;
      dvld_q   <= rsp_d;
      irdata_q <= rsp_i ? i_mem_rdata : '0;
      drdata_q <= (rsp_d & ~st_q) ? i_mem_rdata : '0;
    end
  end
  assign o_imem_vld   = ivld_q;
  assign o_imem_rdata = irdata_q;
  assign o_dmem_vld   = dvld_q;
  assign o_dmem_rdata = drdata_q;
`ifdef MEM_ARB_STATS_EN
  logic [31:0] conf_q, istall_q;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      conf_q   <= '0;
      istall_q <= '0;
    end else begin
      if (idle & i_imem_req & i_dmem_req & ~&conf_q) conf_q <= conf_q + 32'd1;
      if (i_imem_req & ~gnt_i & ~&istall_q) istall_q <= istall_q + 32'd1;
    end
  end
  assign o_conflict_cnt = conf_q;
  assign o_istall_cnt   = istall_q;
`endif
endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed + randomized checks of mem_arb against a transaction-level model.
module tb_mem_arb;
  localparam int SM = 4;
  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic        ireq = 1'b0, dreq = 1'b0, dwen = 1'b0, mvld = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, dwdata = '0, mrdata = '0;
  logic [3:0]  dmask = '0;
  logic        ignt, ivld, dgnt, dvld, mreq, mwen;
  logic [31:0] irdata, drdata, maddr, mwdata;
  logic [3:0]  mmask;
`ifdef MEM_ARB_STATS_EN
  logic [31:0] conf_cnt, istall_cnt;
  int unsigned m_conf = 0, m_istall = 0;
`endif
  int total = 0, bad = 0;
  int m_own = 0, m_starve = 0;
  bit m_drop = 0, m_st = 0;
  bit e_ignt, e_dgnt, e_ivld = 0, e_dvld = 0;
  logic [31:0] e_irdata = '0, e_drdata = '0;

  always #5 clk = ~clk;

  mem_arb dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
    .i_imem_req(ireq), .i_imem_addr(iaddr), .o_imem_gnt(ignt), .o_imem_vld(ivld), .o_imem_rdata(irdata),
    .i_dmem_req(dreq), .i_dmem_wen(dwen), .i_dmem_addr(daddr), .i_dmem_wdata(dwdata), .i_dmem_mask(dmask),
    .o_dmem_gnt(dgnt), .o_dmem_vld(dvld), .o_dmem_rdata(drdata),
    .o_mem_req(mreq), .o_mem_wen(mwen), .o_mem_addr(maddr), .o_mem_wdata(mwdata), .o_mem_mask(mmask),
    .i_mem_vld(mvld), .i_mem_rdata(mrdata)
`ifdef MEM_ARB_STATS_EN
    , .o_conflict_cnt(conf_cnt), .o_istall_cnt(istall_cnt)
`endif
  );

  task automatic model_comb();
    e_ignt = 0;
    e_dgnt = 0;
    if (rst_n && m_own == 0) begin
      e_ignt = ireq && !flush && (!dreq || m_starve >= SM);
      e_dgnt = dreq && !e_ignt;
    end
  endtask

  task automatic advance();
    model_comb();
    @(posedge clk);
    if (!rst_n) begin
      m_own = 0; m_starve = 0; m_drop = 0; m_st = 0;
      e_ivld = 0; e_dvld = 0; e_irdata = '0; e_drdata = '0;
`ifdef MEM_ARB_STATS_EN
      m_conf = 0; m_istall = 0;
`endif
    end else begin
      e_ivld = 0;
      e_dvld = 0;
`ifdef MEM_ARB_STATS_EN
      if (m_own == 0 && ireq && dreq && m_conf != 32'hFFFF_FFFF) m_conf++;
      if (ireq && !e_ignt && m_istall != 32'hFFFF_FFFF) m_istall++;
`endif
      if (m_own == 0) begin
        if (e_ignt || !ireq) m_starve = 0;
        else if (e_dgnt) m_starve = (m_starve < SM) ? m_starve + 1 : SM;
        if (e_dgnt) m_st = dwen;
        m_own = e_ignt ? 1 : e_dgnt ? 2 : 0;
      end else begin
        if (m_own == 1 && flush) m_drop = 1;
        if (mvld) begin
          if (m_own == 1 && !m_drop) begin e_ivld = 1; e_irdata = mrdata; end
          if (m_own == 2) begin e_dvld = 1; e_drdata = m_st ? 32'h0 : mrdata; end
          m_own = 0;
          m_drop = 0;
        end
      end
    end
    #1;
  endtask

  task automatic idle_cycle();
    ireq = 0; dreq = 0; flush = 0; mvld = 0; dwen = 0;
    advance();
  endtask

  task automatic test_reset();
    rst_n = 0; ireq = 1; dreq = 1;
    #1;
    total++; if (ignt !== 1'b0 || dgnt !== 1'b0 || mreq !== 1'b0) begin bad++; $display("FAIL reset_gnt: got i=%b d=%b req=%b want 0", ignt, dgnt, mreq); end
    advance(); advance();
    ireq = 0; dreq = 0;
    total++; if (ivld !== 1'b0 || dvld !== 1'b0 || irdata !== 32'h0 || drdata !== 32'h0) begin bad++; $display("FAIL reset_out: got ivld=%b dvld=%b ir=%h dr=%h want 0", ivld, dvld, irdata, drdata); end
`ifdef MEM_ARB_STATS_EN
    total++; if (conf_cnt !== 32'h0 || istall_cnt !== 32'h0) begin bad++; $display("FAIL reset_stats: got %0d %0d want 0", conf_cnt, istall_cnt); end
`endif
    rst_n = 1;
    advance();
  endtask

  task automatic test_single();
    ireq = 1; iaddr = 32'h100;
    #1;
    total++; if (ignt !== 1'b1 || mreq !== 1'b1 || maddr !== 32'h100 || mwen !== 1'b0) begin bad++; $display("FAIL single_gnt: got gnt=%b req=%b addr=%h wen=%b want 1 1 100 0", ignt, mreq, maddr, mwen); end
    advance();
    ireq = 0;
    #1;
    total++; if (ignt !== 1'b0 || mreq !== 1'b0) begin bad++; $display("FAIL single_busy: got gnt=%b req=%b want 0 0", ignt, mreq); end
    advance();
    mvld = 1; mrdata = 32'h0000_0033;
    advance();
    mvld = 0;
    total++; if (ivld !== 1'b1 || irdata !== 32'h33 || dvld !== 1'b0) begin bad++; $display("FAIL single_vld: got vld=%b rdata=%h dvld=%b want 1 00000033 0", ivld, irdata, dvld); end
    advance();
    total++; if (ivld !== 1'b0) begin bad++; $display("FAIL single_pulse: got vld=%b want 0", ivld); end
  endtask

  task automatic test_priority();
    idle_cycle();
    ireq = 1; iaddr = 32'h200; dreq = 1; dwen = 0; daddr = 32'h300;
    #1;
    total++; if (dgnt !== 1'b1 || ignt !== 1'b0 || maddr !== 32'h300) begin bad++; $display("FAIL prio_pick: got d=%b i=%b addr=%h want 1 0 300", dgnt, ignt, maddr); end
    advance();
    dreq = 0; mvld = 1; mrdata = 32'h55;
    #1;
    total++; if (ignt !== 1'b0) begin bad++; $display("FAIL prio_busy: got igdnt=%b want 0", ignt); end
    advance();
    mvld = 0;
    #1;
    total++; if (dvld !== 1'b1 || drdata !== 32'h55 || ignt !== 1'b1 || maddr !== 32'h200) begin bad++; $display("FAIL prio_next: got dvld=%b dr=%h ignt=%b addr=%h want 1 55 1 200", dvld, drdata, ignt, maddr); end
    advance();
    ireq = 0; mvld = 1; mrdata = 32'h66;
    advance();
    mvld = 0;
    total++; if (ivld !== 1'b1 || irdata !== 32'h66) begin bad++; $display("FAIL prio_ivld: got %b %h want 1 66", ivld, irdata); end
  endtask

  task automatic test_starve();
    int nd = 0;
    bit got = 0;
    idle_cycle();
    ireq = 1; iaddr = 32'h500; dreq = 1; dwen = 0; daddr = 32'h600;
    for (int c = 0; c < 40 && !got; c++) begin
      mvld = (m_own != 0); mrdata = $urandom;
      #1;
      model_comb();
      total++; if (ignt !== e_ignt || dgnt !== e_dgnt) begin bad++; $display("FAIL starve_cyc%0d: got i=%b d=%b want i=%b d=%b", c, ignt, dgnt, e_ignt, e_dgnt); end
      if (dgnt === 1'b1) nd++;
      if (ignt === 1'b1) got = 1;
      advance();
    end
    total++; if (!got || nd != SM) begin bad++; $display("FAIL starve_count: got imem=%b dmem_wins=%0d want 1 %0d", got, nd, SM); end
    ireq = 0; dreq = 0; mvld = 1;
    advance();
    mvld = 0;
    advance();
  endtask

  task automatic test_flush();
    idle_cycle();
    ireq = 1; iaddr = 32'h700; flush = 1;
    #1;
    total++; if (ignt !== 1'b0 || mreq !== 1'b0) begin bad++; $display("FAIL flush_idle: got gnt=%b req=%b want 0 0", ignt, mreq); end
    advance();
    flush = 0; iaddr = 32'h400;
    #1;
    total++; if (ignt !== 1'b1) begin bad++; $display("FAIL flush_gnt: got %b want 1", ignt); end
    advance();
    ireq = 0; flush = 1;
    advance();
    flush = 0; mvld = 1; mrdata = 32'h77;
    advance();
    mvld = 0;
    total++; if (ivld !== 1'b0) begin bad++; $display("FAIL flush_drop: got vld=%b want 0", ivld); end
    ireq = 1; iaddr = 32'h404;
    #1;
    total++; if (ignt !== 1'b1 || maddr !== 32'h404) begin bad++; $display("FAIL flush_idle_after: got gnt=%b addr=%h want 1 404", ignt, maddr); end
    advance();
    ireq = 0; mvld = 1; mrdata = 32'h88;
    advance();
    mvld = 0;
    total++; if (ivld !== 1'b1 || irdata !== 32'h88) begin bad++; $display("FAIL flush_recover: got %b %h want 1 88", ivld, irdata); end
  endtask

  task automatic test_store();
    idle_cycle();
    dreq = 1; dwen = 1; daddr = 32'h40; dwdata = 32'hDEAD_BEEF; dmask = 4'b0011;
    #1;
    total++; if (dgnt !== 1'b1 || mreq !== 1'b1 || mwen !== 1'b1 || maddr !== 32'h40 || mwdata !== 32'hDEAD_BEEF || mmask !== 4'b0011) begin bad++; $display("FAIL store_bus: got g=%b r=%b w=%b a=%h d=%h m=%b want 1 1 1 40 deadbeef 0011", dgnt, mreq, mwen, maddr, mwdata, mmask); end
    advance();
    dreq = 0; dwen = 0; mvld = 1; mrdata = 32'h1234_5678;
    advance();
    mvld = 0;
    total++; if (dvld !== 1'b1 || drdata !== 32'h0) begin bad++; $display("FAIL store_ack: got vld=%b rdata=%h want 1 0", dvld, drdata); end
  endtask

  task automatic test_reset_mid();
    idle_cycle();
    ireq = 1; iaddr = 32'h90; dreq = 1; dwen = 0; daddr = 32'h80;
    #1;
    total++; if (dgnt !== 1'b1) begin bad++; $display("FAIL rmid_gnt: got %b want 1", dgnt); end
    advance();
    ireq = 0; dreq = 0; rst_n = 0;
    advance();
    rst_n = 1; mvld = 1; mrdata = 32'h99;
    advance();
    mvld = 0;
    total++; if (ivld !== 1'b0 || dvld !== 1'b0 || drdata !== 32'h0) begin bad++; $display("FAIL rmid_stale: got ivld=%b dvld=%b dr=%h want 0 0 0", ivld, dvld, drdata); end
    ireq = 1; iaddr = 32'hA0;
    #1;
    total++; if (ignt !== 1'b1) begin bad++; $display("FAIL rmid_idle: got %b want 1", ignt); end
    advance();
    ireq = 0; mvld = 1; mrdata = 32'hAA;
    advance();
    mvld = 0;
    total++; if (ivld !== 1'b1 || irdata !== 32'hAA) begin bad++; $display("FAIL rmid_after: got %b %h want 1 aa", ivld, irdata); end
`ifdef MEM_ARB_STATS_EN
    total++; if (conf_cnt !== m_conf || istall_cnt !== m_istall) begin bad++; $display("FAIL rmid_stats: got %0d %0d want %0d %0d", conf_cnt, istall_cnt, m_conf, m_istall); end
`endif
  endtask

  task automatic test_random();
    bit pend_on = 0;
    int pend = 0;
    idle_cycle();
    for (int c = 0; c < 600; c++) begin
      if (!ireq && $urandom_range(0, 2) == 0) begin ireq = 1; iaddr = $urandom & 32'hFFFF_FFFC; end
      if (!dreq && $urandom_range(0, 2) == 0) begin
        dreq = 1; dwen = 1'($urandom_range(0, 1)); daddr = $urandom; dwdata = $urandom; dmask = 4'($urandom);
      end
      flush = ($urandom_range(0, 7) == 0);
      mvld = pend_on ? (pend == 0) : (m_own == 0 && $urandom_range(0, 9) == 0);
      mrdata = $urandom;
      #1;
      model_comb();
      total++; if (ignt !== e_ignt || dgnt !== e_dgnt || mreq !== (e_ignt | e_dgnt)) begin bad++; $display("FAIL rnd_gnt%0d: got i=%b d=%b r=%b want i=%b d=%b", c, ignt, dgnt, mreq, e_ignt, e_dgnt); end
      if (e_dgnt) begin
        total++; if (maddr !== daddr || mwen !== dwen || mwdata !== dwdata || mmask !== dmask) begin bad++; $display("FAIL rnd_dbus%0d: got a=%h w=%b d=%h m=%b want a=%h w=%b d=%h m=%b", c, maddr, mwen, mwdata, mmask, daddr, dwen, dwdata, dmask); end
      end
      if (e_ignt) begin
        total++; if (maddr !== iaddr || mwen !== 1'b0) begin bad++; $display("FAIL rnd_ibus%0d: got a=%h w=%b want a=%h w=0", c, maddr, mwen, iaddr); end
      end
      advance();
      total++; if (ivld !== e_ivld || dvld !== e_dvld) begin bad++; $display("FAIL rnd_vld%0d: got i=%b d=%b want i=%b d=%b", c, ivld, dvld, e_ivld, e_dvld); end
      if (e_ivld) begin
        total++; if (irdata !== e_irdata) begin bad++; $display("FAIL rnd_ird%0d: got %h want %h", c, irdata, e_irdata); end
      end
      if (e_dvld) begin
        total++; if (drdata !== e_drdata) begin bad++; $display("FAIL rnd_drd%0d: got %h want %h", c, drdata, e_drdata); end
      end
      if (pend_on && pend == 0) pend_on = 0;
      else if (pend_on) pend--;
      if (e_ignt || e_dgnt) begin pend_on = 1; pend = $urandom_range(0, 2); end
      if (e_ignt) ireq = 0;
      if (e_dgnt) dreq = 0;
    end
    ireq = 0; dreq = 0; flush = 0;
    for (int c = 0; c < 10; c++) begin
      mvld = (m_own != 0);
      advance();
    end
    mvld = 0;
    total++; if (m_own != 0) begin bad++; $display("FAIL rnd_drain: model owner=%0d want 0", m_own); end
`ifdef MEM_ARB_STATS_EN
    total++; if (conf_cnt !== m_conf || istall_cnt !== m_istall) begin bad++; $display("FAIL rnd_stats: got %0d %0d want %0d %0d", conf_cnt, istall_cnt, m_conf, m_istall); end
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: sim time expired total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_starve();
    test_flush();
    test_store();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
